// File: rtl/serial_pkg.sv
// Shared types for the serial operand transmitter: FSM states, bit order and
// the parallel compare result carried alongside each transaction.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } order_e;

  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } cmp_t;

  // Beat counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_operand_transmitter_if.sv
// Operand-in / bit-pair-out bundle of the serial operand transmitter.
interface serial_operand_transmitter_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_msb_first;
  logic             out_valid;
  logic             out_ready;
  logic             out_a;
  logic             out_b;
  logic             out_first;
  logic             out_last;
  logic             exp_less;
  logic             exp_eq;
  logic             exp_greater;

  // Environment side: offers operand pairs and consumes bit pairs.
  modport master (
    output in_valid, in_a, in_b, in_msb_first, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last,
           exp_less, exp_eq, exp_greater
  );

  // Transmitter side.
  modport slave (
    input  in_valid, in_a, in_b, in_msb_first, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last,
           exp_less, exp_eq, exp_greater
  );
endinterface

// File: rtl/serial_shift_lane.sv
// One operand lane: parallel load with bit-order select, then right shift with
// the serial bit always taken straight from the register LSB.
module serial_shift_lane
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  order_e           order,
  input  logic [WIDTH-1:0] din,
  output logic             ser_out
);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] din_rev;

  // MSB-first is handled by loading the word reversed, so the output is a
  // plain flop bit regardless of order.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      din_rev[i] = din[int'(WIDTH) - 1 - i];
    end
  end

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = (order == ORDER_MSB_FIRST) ? din_rev : din;
    end else if (shift) begin
      sh_d = sh_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign ser_out = sh_q[0];

endmodule

// File: rtl/serial_operand_transmitter.sv
// Parallel-to-serial source: accepts an operand pair, streams it one bit pair
// per beat and flags the parallel compare result for the word in flight.
module serial_operand_transmitter
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                         clk,
  input logic                         rst,
  serial_operand_transmitter_if.slave bus
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  cmp_t          cmp_q, cmp_d;

  logic beat_done_c;
  logic in_ready_c;
  logic load_c;

  assign beat_done_c = (state_q == ST_SHIFT) && bus.out_ready;
  // Accepting on the last beat keeps the stream bubble-free.
  assign in_ready_c  = (state_q == ST_IDLE) || (beat_done_c && last_q);
  assign load_c      = bus.in_valid && in_ready_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    cmp_d   = cmp_q;
    if (load_c) begin
      state_d       = ST_SHIFT;
      cnt_d         = '0;
      first_d       = 1'b1;
      last_d        = (CNT_LAST == '0);
      cmp_d.less    = (bus.in_a < bus.in_b);
      cmp_d.eq      = (bus.in_a == bus.in_b);
      cmp_d.greater = (bus.in_a > bus.in_b);
    end else if (beat_done_c) begin
      if (last_q) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        first_d = 1'b0;
        last_d  = 1'b0;
        cmp_d   = '0;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        first_d = 1'b0;
        last_d  = (cnt_d == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      cmp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      cmp_q   <= cmp_d;
    end
  end

  serial_shift_lane #(.WIDTH(WIDTH)) u_lane_a (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .shift   (beat_done_c),
    .order   (order_e'(bus.in_msb_first)),
    .din     (bus.in_a),
    .ser_out (bus.out_a)
  );

  serial_shift_lane #(.WIDTH(WIDTH)) u_lane_b (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .shift   (beat_done_c),
    .order   (order_e'(bus.in_msb_first)),
    .din     (bus.in_b),
    .ser_out (bus.out_b)
  );

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = (state_q == ST_SHIFT);
  assign bus.out_first   = first_q;
  assign bus.out_last    = last_q;
  assign bus.exp_less    = cmp_q.less;
  assign bus.exp_eq      = cmp_q.eq;
  assign bus.exp_greater = cmp_q.greater;

endmodule

// File: tb/tb_serial_operand_transmitter.sv
// Bench for serial_operand_transmitter: table-driven transactions through a
// beat scoreboard, plus stall, mid-word reset, back-to-back and WIDTH=1 cases.
module tb_serial_operand_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_operand_transmitter_if #(.WIDTH(16)) ifc16 ();
  serial_operand_transmitter_if #(.WIDTH(1))  ifc1 ();

  serial_operand_transmitter #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));
  serial_operand_transmitter #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(ifc1));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic a, b, first, last, less, eq, greater;
  } beat_t;

  // sa/sb hold the expected serial streams with beat 0 in bit 15.
  typedef struct {
    logic [15:0] a, b;
    logic        msb;
    logic [15:0] sa, sb;
    logic        less, eq, greater;
  } vec_t;

  beat_t sbq[$];
  vec_t  vecs[6];
  beat_t mon_e;
  int    valid_cycles = 0;
  logic  prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_vec(input vec_t v);
    beat_t e;
    for (int k = 0; k < 16; k++) begin
      e.a       = v.sa[15-k];
      e.b       = v.sb[15-k];
      e.first   = (k == 0);
      e.last    = (k == 15);
      e.less    = v.less;
      e.eq      = v.eq;
      e.greater = v.greater;
      sbq.push_back(e);
    end
  endtask

  task automatic send(input vec_t v);
    logic done;
    done = 1'b0;
    @(negedge clk);
    ifc16.in_valid     = 1'b1;
    ifc16.in_a         = v.a;
    ifc16.in_b         = v.b;
    ifc16.in_msb_first = v.msb;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (ifc16.in_ready) begin
        push_vec(v);
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    ifc16.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      #3;
      if (sbq.size() == 0 && !ifc16.out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", sbq.size());
    end
  endtask

  task automatic wait_pending(input int n);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (sbq.size() == n) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL pending_timeout: got %0d beats pending expected %0d", sbq.size(), n);
    end
  endtask

  // Beat monitor, sampled mid-low-phase after the drivers have settled.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      chk("in_ready", 32'(ifc16.in_ready),
          32'(!ifc16.out_valid || (ifc16.out_ready && ifc16.out_last)));
      if (ifc16.out_valid) begin
        valid_cycles++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got out_valid=1 expected no beat at %0t", $time);
        end else begin
          mon_e = sbq[0];
          chk("beat", 32'({ifc16.out_a, ifc16.out_b, ifc16.out_first, ifc16.out_last,
                           ifc16.exp_less, ifc16.exp_eq, ifc16.exp_greater}),
              32'({mon_e.a, mon_e.b, mon_e.first, mon_e.last,
                   mon_e.less, mon_e.eq, mon_e.greater}));
          if (ifc16.out_ready) void'(sbq.pop_front());
        end
      end else begin
        chk("idle_flags", 32'({ifc16.out_first, ifc16.out_last, ifc16.exp_less,
                               ifc16.exp_eq, ifc16.exp_greater}), 32'd0);
        if (prev_valid) chk("bubble_pending", 32'(sbq.size()), 32'd0);
      end
      prev_valid = ifc16.out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a:16'h6482, b:16'h6262, msb:1'b1, sa:16'h6482, sb:16'h6262, less:1'b0, eq:1'b0, greater:1'b1};
    vecs[1] = '{a:16'h6482, b:16'h6262, msb:1'b0, sa:16'h4126, sb:16'h4646, less:1'b0, eq:1'b0, greater:1'b1};
    vecs[2] = '{a:16'h0001, b:16'h0002, msb:1'b1, sa:16'h0001, sb:16'h0002, less:1'b1, eq:1'b0, greater:1'b0};
    vecs[3] = '{a:16'hFFFF, b:16'hFFFF, msb:1'b1, sa:16'hFFFF, sb:16'hFFFF, less:1'b0, eq:1'b1, greater:1'b0};
    vecs[4] = '{a:16'h8000, b:16'h0001, msb:1'b0, sa:16'h0001, sb:16'h8000, less:1'b0, eq:1'b0, greater:1'b1};
    vecs[5] = '{a:16'h0000, b:16'hFFFF, msb:1'b0, sa:16'h0000, sb:16'hFFFF, less:1'b1, eq:1'b0, greater:1'b0};

    ifc16.in_valid = 1'b0; ifc16.in_a = '0; ifc16.in_b = '0; ifc16.in_msb_first = 1'b0;
    ifc16.out_ready = 1'b1;
    ifc1.in_valid = 1'b0; ifc1.in_a = '0; ifc1.in_b = '0; ifc1.in_msb_first = 1'b0;
    ifc1.out_ready = 1'b1;

    #1;
    chk("reset_outputs16", 32'({ifc16.out_valid, ifc16.out_a, ifc16.out_b, ifc16.out_first,
                                ifc16.out_last, ifc16.exp_less, ifc16.exp_eq, ifc16.exp_greater}), 32'd0);
    chk("reset_outputs1", 32'({ifc1.out_valid, ifc1.out_a, ifc1.out_b, ifc1.out_first,
                               ifc1.out_last, ifc1.exp_less, ifc1.exp_eq, ifc1.exp_greater}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("in_ready_after_reset", 32'(ifc16.in_ready), 32'd1);

    // Table-driven single transactions, full-rate consumer.
    for (int i = 0; i < 6; i++) begin
      send(vecs[i]);
      drop_valid();
      wait_drain();
    end

    // Back-to-back pairs with in_valid held: 32 beats, no bubble.
    valid_cycles = 0;
    send(vecs[2]);
    send(vecs[3]);
    drop_valid();
    wait_drain();
    chk("b2b_valid_cycles", 32'(valid_cycles), 32'd32);

    // Three-cycle stall at beat 5.
    valid_cycles = 0;
    send(vecs[0]);
    drop_valid();
    wait_pending(11);
    ifc16.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    ifc16.out_ready = 1'b1;
    wait_drain();
    chk("stall_valid_cycles", 32'(valid_cycles), 32'd19);

    // Reset at beat 7 discards the word.
    send(vecs[1]);
    drop_valid();
    wait_pending(9);
    rst = 1'b0;
    #1;
    chk("reset_mid_outputs", 32'({ifc16.out_valid, ifc16.out_a, ifc16.out_b, ifc16.out_first,
                                  ifc16.out_last, ifc16.exp_less, ifc16.exp_eq, ifc16.exp_greater}), 32'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset_ready_valid", 32'({ifc16.in_ready, ifc16.out_valid}), 32'b10);
    send(vecs[4]);
    drop_valid();
    wait_drain();

    // WIDTH=1: a single beat that is both first and last.
    @(negedge clk);
    ifc1.in_valid = 1'b1; ifc1.in_a = 1'b1; ifc1.in_b = 1'b0; ifc1.in_msb_first = 1'b1;
    #1;
    chk("w1_in_ready", 32'(ifc1.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("w1_beat", 32'({ifc1.out_valid, ifc1.out_first, ifc1.out_last, ifc1.out_a, ifc1.out_b,
                        ifc1.exp_less, ifc1.exp_eq, ifc1.exp_greater}), 32'b1111_0001);
    @(negedge clk);
    ifc1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("w1_done", 32'({ifc1.out_valid, ifc1.in_ready, ifc1.exp_greater}), 32'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_operand_transmitter.md
# serial_operand_transmitter

Parallel-to-serial source for the serial comparator datapath. Accepts a pair of unsigned WIDTH-bit operands over a valid/ready handshake and emits them as two synchronous 1-bit streams, one bit pair per beat. Bit order is chosen per transaction: MSB-first or LSB-first. Per-transaction reference flags give the parallel comparison result, so downstream comparators can be checked at the last beat.

## Interface
- WIDTH, 16, operand width in bits (≥1)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset; one clock; reset is asynchronous and active-low
- in_valid  input  1  operand pair offered
- in_ready  output  1  transmitter can accept a pair this cycle
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_msb_first  input  1  1 = MSB-first order, 0 = LSB-first; sampled with the pair
- out_valid  output  1  out_a/out_b carry a valid bit pair
- out_ready  input  1  consumer takes the current bit pair
- out_a  output  1  current bit of a
- out_b  output  1  current bit of b
- out_first  output  1  current beat is bit 0 of the transaction
- out_last  output  1  current beat is bit WIDTH-1 of the transaction
- exp_less / exp_eq / exp_greater  output  1 each  unsigned in_a <, ==, > in_b for the transaction in flight

## Operation
- Two-state FSM: IDLE, SHIFT.
- IDLE: in_ready=1, out_valid=0. On in_valid: latch in_a, in_b, in_msb_first and the parallel compare; load beat counter = 0; go to SHIFT.
- SHIFT:
  - out_valid=1.
  - out_a/out_b = latched bit [WIDTH-1-cnt] if MSB-first, else bit [cnt]; implemented as shift registers, not muxes.
  - out_first = (cnt==0); out_last = (cnt==WIDTH-1).
  - A beat completes when out_valid & out_ready: counter increments and registers shift.
- Last-beat completion:
  - If in_valid is high that cycle, the new pair is loaded and SHIFT continues with cnt=0, with no bubble.
  - Otherwise the FSM returns to IDLE.
  - in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
- Counter width $clog2(WIDTH) (minimum 1). It never wraps past WIDTH-1 and is reset to 0 on load.
- WIDTH=1: out_first and out_last both high on the single beat.
- exp_* flags: exactly one is high while out_valid=1. They are held stable for the whole transaction and are 0 in IDLE.
- Reset mid-transaction: the partial word is discarded. The FSM goes to IDLE, and no further beats of that word appear.

## Timing
- Reset values: out_valid=0, out_a=0, out_b=0, out_first=0, out_last=0, exp_*=0, state IDLE. in_ready=1 once rst is released. All outputs clear asynchronously on rst low.
- Latency: a pair accepted at rising edge N produces its first beat (out_first=1) visible after edge N; it is consumed at edge N+1 if out_ready is high.
- Throughput: one bit pair per cycle with out_ready held high, so WIDTH cycles per transaction, back-to-back.
- Stall: while out_ready=0, every output except in_ready holds its value. in_ready stays 0 during SHIFT.
- The handshake obeys valid/ready rules: out_valid never drops without a completed beat, except on reset. out_* do not depend combinationally on out_ready.
- in_ready may depend combinationally on out_ready on the last beat. No other combinational in→out paths exist.

## Structure
- Shared package serial_pkg:
  - state enum (ST_IDLE, ST_SHIFT);
  - bit-order enum (ORDER_LSB_FIRST=0, ORDER_MSB_FIRST=1);
  - compare-result struct {less, eq, greater}.
- One sub-module, serial_shift_lane, instantiated twice (a and b). It contains a WIDTH-bit load/shift register with a direction select and serial output.
- FSM, counter, handshake and compare logic live in the top level.

## Test plan
- WIDTH=16, a=16'h6482, b=16'h6262, MSB-first, out_ready=1 → out_a = 0110_0100_1000_0010 and out_b = 0110_0010_0110_0010 over 16 beats. out_first on beat 0, out_last on beat 15, exp_greater=1 throughout.
- Same operands, LSB-first → out_a = 0100_0001_0010_0110 (bits 0..15), out_last on beat 15, exp_greater=1.
- Back-to-back pairs (16'h0001, 16'h0002) then (16'hFFFF, 16'hFFFF) with in_valid held → 32 consecutive valid beats with no bubble. in_ready pulses on beat 15. Flags go exp_less, then exp_eq.
- out_ready=0 for 3 cycles at beat 5 → outputs frozen for 3 cycles. Beats 5..15 then resume unchanged, for 19 cycles total.
- rst asserted low at beat 7 → all outputs 0 immediately. After release: in_ready=1, out_valid=0, and the next pair starts cleanly at beat 0.
- WIDTH=1, a=1, b=0 → a single beat with out_first=out_last=1, out_a=1, out_b=0, exp_greater=1.
